// File: rtl/se_sram_srw_be_clr.sv
// Single-port synchronous SRAM with per-lane byte enables, 1- or 2-cycle read pipeline,
// read_valid strobe and a hardware fill sequencer that scrubs the array after reset or on request.
module se_sram_srw_be_clr #(
    parameter int unsigned address_width = 10,
    parameter int unsigned data_width    = 32,
    parameter int unsigned lane_width    = 8,
    parameter int unsigned read_latency  = 1,
    parameter logic [data_width-1:0] clear_value = '0
) (
    input  logic                                sram_clock,
    input  logic                                reset_n,
    input  logic                                sram_clock__enable,
    input  logic                                select,
    input  logic                                read_not_write,
    input  logic [address_width-1:0]            address,
    input  logic [data_width-1:0]               write_data,
    input  logic [(data_width/lane_width)-1:0]  write_enable,
    input  logic                                clear_request,
    output logic                                busy,
    output logic [data_width-1:0]               data_out,
    output logic                                read_valid
);

    localparam int unsigned lanes = data_width / lane_width;
    localparam int unsigned depth = 2 ** address_width;
    localparam logic [address_width-1:0] last_addr = '1;

    // Parameter sanity: stop elaboration on unsupported configurations.
    if ((data_width % lane_width) != 0) begin : g_bad_lane_width
        $error("se_sram_srw_be_clr: data_width must be a multiple of lane_width");
    end
    if ((read_latency != 1) && (read_latency != 2)) begin : g_bad_read_latency
        $error("se_sram_srw_be_clr: read_latency must be 1 or 2");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [address_width-1:0]   cnt_q;
    logic [address_width-1:0]   cnt_d;
    logic                       busy_d;

    logic                       mem_we_c;
    logic [address_width-1:0]   mem_addr_c;
    logic [data_width-1:0]      mem_wdata_c;
    logic [lanes-1:0]           mem_lane_we_c;
    logic [data_width-1:0]      bit_mask_c;
    logic                       rd_req_c;

    logic [data_width-1:0]      mem [depth];

    // State, fill counter and busy flag; everything freezes while the clock enable is low.
    always_ff @(posedge sram_clock or negedge reset_n) begin : p_state
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy    <= 1'b1;
        end else if (sram_clock__enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
        end
    end

    // Next-state and array port steering: the sequencer owns the port while clearing.
    always_comb begin : p_next
        state_d       = state_q;
        cnt_d         = cnt_q;
        busy_d        = busy;
        mem_we_c      = 1'b0;
        mem_addr_c    = address;
        mem_wdata_c   = write_data;
        mem_lane_we_c = write_enable;
        rd_req_c      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we_c      = 1'b1;
                mem_addr_c    = cnt_q;
                mem_wdata_c   = clear_value;
                mem_lane_we_c = '1;
                cnt_d         = cnt_q + address_width'(1);
                if (cnt_q == last_addr) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (clear_request) begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else if (select) begin
                    if (read_not_write) begin
                        rd_req_c = 1'b1;
                    end else begin
                        mem_we_c = |write_enable;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                busy_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    // Expand the lane enables into a bit mask.
    for (genvar g = 0; g < lanes; g++) begin : g_lane_mask
        assign bit_mask_c[g*lane_width +: lane_width] = {lane_width{mem_lane_we_c[g]}};
    end

    // Array write: masked lanes keep their previous contents.
    always_ff @(posedge sram_clock) begin : p_array_write
        if (sram_clock__enable && mem_we_c) begin
            mem[mem_addr_c] <= (mem[mem_addr_c] & ~bit_mask_c) | (mem_wdata_c & bit_mask_c);
        end
    end

    if (read_latency == 1) begin : g_read_lat1
        // Array output registered straight to data_out.
        always_ff @(posedge sram_clock or negedge reset_n) begin : p_read
            if (!reset_n) begin
                data_out   <= '0;
                read_valid <= 1'b0;
            end else if (sram_clock__enable) begin
                read_valid <= rd_req_c;
                if (rd_req_c) begin
                    data_out <= mem[address];
                end
            end
        end
    end else begin : g_read_lat2
        logic [data_width-1:0] stage_data_q;
        logic                  stage_valid_q;

        // Extra output stage; it keeps draining after a fill starts since it already holds the data.
        always_ff @(posedge sram_clock or negedge reset_n) begin : p_read
            if (!reset_n) begin
                stage_data_q  <= '0;
                stage_valid_q <= 1'b0;
                data_out      <= '0;
                read_valid    <= 1'b0;
            end else if (sram_clock__enable) begin
                stage_valid_q <= rd_req_c;
                if (rd_req_c) begin
                    stage_data_q <= mem[address];
                end
                read_valid <= stage_valid_q;
                if (stage_valid_q) begin
                    data_out <= stage_data_q;
                end
            end
        end
    end

endmodule
